bubble_sort_pass_sched: RTL and testbench
=========================================

// Module: bubble_sort_pass_sched
// PURPOSE
//  Outer-loop sequencer for bubble_sort: accepts a block-level ap_ctrl_hs start, then issues
//  one start per sort pass to the pipelined compare-swap inner loop, with a shrinking trip
//  count per pass. Sits between the top-level ap_start/ap_done and the inner-loop instance.
//  Replaces the fixed 4-state outer FSM with a length-programmable pass scheduler.
// PARAMETERS
//  IDX_W   5   width of length, trip-count and pass-count fields; max len = 2**IDX_W-1
// PORTS
//  clock         in   1      single clock, rising edge
//  reset         in   1      asynchronous, active-high
//  ap_start      in   1      block start; sampled only in IDLE
//  ap_done       out  1      one-cycle pulse, sort complete
//  ap_ready      out  1      one-cycle pulse, coincident with ap_done
//  ap_idle       out  1      high in IDLE only
//  len           in   IDX_W  element count; captured when ap_start is accepted
//  pass_start    out  1      inner-loop start; held until pass_ready seen
//  pass_ready    in   1      inner loop accepted pass_start
//  pass_done     in   1      inner loop finished current pass (one-cycle pulse)
//  pass_swapped  in   1      at least one swap this pass; valid only with pass_done
//  pass_bound    out  IDX_W  inner trip count = len_r-1-pass_r; stable while pass_start=1
//  pass_count    out  IDX_W  passes completed; valid at ap_done, held until next accept
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; ap_idle=1; all other outputs, len_r, pass_r,
//   swap_r = 0. Reset mid-pass abandons the operation; no ap_done is produced.
//  States: IDLE, LAUNCH, WAIT, CHECK, DONE (registered, one-hot or binary).
//  IDLE:   ap_start=1 -> capture len_r=len, pass_r=0, pass_count=0;
//           len_r<=1 -> DONE (no pass issued), else -> LAUNCH.
//  LAUNCH: pass_start=1, pass_bound=len_r-1-pass_r. Stay until pass_ready=1.
//           pass_ready & pass_done same cycle -> capture swap_r, -> CHECK; pass_ready only -> WAIT.
//  WAIT:   pass_start=0. On pass_done: swap_r=pass_swapped, -> CHECK.
//  CHECK:  pass_r+=1, pass_count=pass_r+1. If pass_r+1 == len_r-1 -> DONE, else -> LAUNCH
//           (early-exit rule under CONFIGURATION).
//  DONE:   ap_done=ap_ready=1 for exactly one cycle (ap_continue tied high) -> IDLE.
//  Latency: 1 cycle IDLE->LAUNCH; per pass = launch wait + inner latency + 1 (CHECK);
//   +1 cycle DONE. len<=1: ap_done exactly 2 cycles after accepted ap_start.
//  ap_start outside IDLE ignored; ap_start held high -> next op accepted the cycle after DONE.
//  pass_done/pass_swapped outside LAUNCH/WAIT ignored. len changes after capture ignored.
//  Arithmetic unsigned, IDX_W bits; pass_bound never underflows (len_r>=2 whenever issued).
// CONFIGURATION
//  BUBBLE_SORT_EARLY_EXIT_EN defined: in CHECK, swap_r=0 also -> DONE (array already
//   sorted); pass_count reports passes actually run.
//  Not defined: pass_swapped unused; always exactly len_r-1 passes.
// TESTING
//  1. len=5, pass_ready in launch cycle, pass_done 3 cycles later, swapped=1 ->
//     4 passes, pass_bound 4,3,2,1, single ap_done/ap_ready pulse, pass_count=4.
//  2. len=0 and len=1 -> pass_start never asserted, ap_done 2 cycles after start, pass_count=0.
//  3. len=8, swapped=1,1,0 -> with EARLY_EXIT_EN ap_done after pass 3, pass_count=3;
//     without it 7 passes, pass_count=7.
//  4. pass_ready delayed 3 cycles -> pass_start held 4 cycles, pass_bound stable throughout.
//  5. reset high during WAIT of pass 2 -> same-cycle ap_idle=1, pass_start=0, no ap_done;
//     next start with len=3 completes 2 passes normally.
//  6. ap_start held high, len=3 -> back-to-back ops, 2nd accepted cycle after 1st ap_done,
//     ap_start pulses during LAUNCH/WAIT ignored.

Source files
------------

// File: rtl/bubble_sort_pass_sched_if.sv
//------------------------------------------------------------------------------
// Module : bubble_sort_pass_sched_if
// Brief  : Block-level ap_ctrl_hs handshake and inner-loop pass handshake bundle.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface bubble_sort_pass_sched_if #(
  parameter int IDX_W = 5
);
  logic             ap_start;
  logic             ap_done;
  logic             ap_ready;
  logic             ap_idle;
  logic [IDX_W-1:0] len;
  logic             pass_start;
  logic             pass_ready;
  logic             pass_done;
  logic             pass_swapped;
  logic [IDX_W-1:0] pass_bound;
  logic [IDX_W-1:0] pass_count;

  // master is the scheduler; slave is the surrounding block (top control + inner loop)
  modport master (
    input  ap_start, len, pass_ready, pass_done, pass_swapped,
    output ap_done, ap_ready, ap_idle, pass_start, pass_bound, pass_count
  );

  modport slave (
    output ap_start, len, pass_ready, pass_done, pass_swapped,
    input  ap_done, ap_ready, ap_idle, pass_start, pass_bound, pass_count
  );
endinterface

`default_nettype wire

// File: rtl/bubble_sort_pass_sched.sv
//------------------------------------------------------------------------------
// Module : bubble_sort_pass_sched
// Brief  : Outer-loop pass scheduler for bubble_sort; optional early exit when a
//          pass makes no swap is enabled by defining BUBBLE_SORT_EARLY_EXIT_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bubble_sort_pass_sched #(
  parameter int IDX_W = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  bubble_sort_pass_sched_if.master      bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] len_r;
  logic [IDX_W-1:0] pass_r;
  logic [IDX_W-1:0] pass_count_r;
  logic [IDX_W-1:0] pass_next;
  logic             last_pass;
  logic             finish;
  logic             accept;
  logic             pass_end;

  assign accept    = (state == S_IDLE) && bus.ap_start;
  assign pass_next = pass_r + IDX_W'(1);
  assign last_pass = (pass_next == (len_r - IDX_W'(1)));
  // a pass ends either in the launch cycle (ready and done together) or later in WAIT
  assign pass_end  = ((state == S_LAUNCH) && bus.pass_ready && bus.pass_done) ||
                     ((state == S_WAIT) && bus.pass_done);

`ifdef BUBBLE_SORT_EARLY_EXIT_EN
  logic swap_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_r <= 1'b0;
    end else if (accept) begin
      swap_r <= 1'b0;
    end else if (pass_end) begin
      swap_r <= bus.pass_swapped;
    end
  end

  // a pass with no swap proves the array is already sorted
  assign finish = last_pass || !swap_r;
`else
  assign finish = last_pass;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (bus.ap_start) begin
          next_state = (bus.len <= IDX_W'(1)) ? S_DONE : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (bus.pass_ready) begin
          next_state = bus.pass_done ? S_CHECK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.pass_done) begin
          next_state = S_CHECK;
        end
      end
      S_CHECK: begin
        next_state = finish ? S_DONE : S_LAUNCH;
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r        <= '0;
      pass_r       <= '0;
      pass_count_r <= '0;
    end else if (accept) begin
      len_r        <= bus.len;
      pass_r       <= '0;
      pass_count_r <= '0;
    end else if (state == S_CHECK) begin
      pass_r       <= pass_next;
      pass_count_r <= pass_next;
    end
  end

  // len_r >= 2 whenever LAUNCH is reached, so the bound never underflows
  assign bus.pass_bound = (state == S_LAUNCH) ? (len_r - IDX_W'(1) - pass_r) : '0;
  assign bus.pass_start = (state == S_LAUNCH);
  assign bus.ap_idle    = (state == S_IDLE);
  assign bus.ap_done    = (state == S_DONE);
  assign bus.ap_ready   = (state == S_DONE);
  assign bus.pass_count = pass_count_r;

endmodule

`default_nettype wire

// File: tb/tb_bubble_sort_pass_sched.sv
//------------------------------------------------------------------------------
// Module : tb_bubble_sort_pass_sched
// Brief  : Scoreboard bench: directed ops queue expected passes/done; monitor checks.
// Rev    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_bubble_sort_pass_sched;
  localparam int IDX_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bubble_sort_pass_sched_if #(.IDX_W(IDX_W)) bus ();

  bubble_sort_pass_sched #(.IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit is_done;
    int value;
    int hold;
  } exp_t;

  exp_t exp_q[$];
  bit   swap_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   ready_dly = 0;
  int   done_dly  = 3;
  bit   resp_busy = 1'b0;
  int   hold_cnt  = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pass(input int bound);
    exp_q.push_back('{1'b0, bound, ready_dly + 1});
  endtask

  task automatic push_done(input int count);
    exp_q.push_back('{1'b1, count, 0});
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || resp_busy) && n < budget) begin
      tick();
      n++;
    end
    check({"drain_", name}, exp_q.size(), 0);
    exp_q.delete();
    swap_q.delete();
    repeat (2) tick();
  endtask

  task automatic start_op(input int l);
    bus.len      = IDX_W'(l);
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a pass handshake or ap_done
  always @(negedge clk) begin
    bit want;
    if (rst) begin
      hold_cnt = 0;
    end else begin
      if (bus.pass_start) begin
        want = (exp_q.size() != 0) && !exp_q[0].is_done;
        check("pass_start_expected", int'(want), 1);
        if (want) begin
          hold_cnt++;
          check("pass_bound", int'(bus.pass_bound), exp_q[0].value);
          if (bus.pass_ready) begin
            check("pass_start_hold", hold_cnt, exp_q[0].hold);
            void'(exp_q.pop_front());
            hold_cnt = 0;
          end
        end
      end
      if (bus.ap_done) begin
        want = (exp_q.size() != 0) && exp_q[0].is_done;
        check("ap_done_expected", int'(want), 1);
        check("ap_ready_with_done", int'(bus.ap_ready), 1);
        if (want) begin
          check("pass_count", int'(bus.pass_count), exp_q[0].value);
          void'(exp_q.pop_front());
        end
      end else if (bus.ap_ready) begin
        check("ap_ready_without_done", int'(bus.ap_ready), 0);
      end
    end
  end

  // inner-loop model: accepts after ready_dly cycles, finishes done_dly cycles after accept
  initial begin
    bus.pass_ready   = 1'b0;
    bus.pass_done    = 1'b0;
    bus.pass_swapped = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && bus.pass_start) begin
        bit sw;
        resp_busy = 1'b1;
        sw = (swap_q.size() != 0) ? swap_q.pop_front() : 1'b1;
        repeat (ready_dly) begin
          @(posedge clk);
          #1;
        end
        bus.pass_ready = 1'b1;
        if (done_dly == 0) begin
          bus.pass_done    = 1'b1;
          bus.pass_swapped = sw;
        end
        @(posedge clk);
        #1;
        bus.pass_ready   = 1'b0;
        bus.pass_done    = 1'b0;
        bus.pass_swapped = 1'b0;
        if (done_dly > 0) begin
          repeat (done_dly - 1) begin
            @(posedge clk);
            #1;
          end
          bus.pass_done    = 1'b1;
          bus.pass_swapped = sw;
          @(posedge clk);
          #1;
          bus.pass_done    = 1'b0;
          bus.pass_swapped = 1'b0;
        end
        resp_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int passes;
    bus.ap_start = 1'b0;
    bus.len      = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ap_idle",     int'(bus.ap_idle),    1);
    check("rst_ap_done",     int'(bus.ap_done),    0);
    check("rst_ap_ready",    int'(bus.ap_ready),   0);
    check("rst_pass_start",  int'(bus.pass_start), 0);
    check("rst_pass_bound",  int'(bus.pass_bound), 0);
    check("rst_pass_count",  int'(bus.pass_count), 0);
    tick();

    // len=5: four passes with shrinking bound
    ready_dly = 0; done_dly = 3;
    push_pass(4); push_pass(3); push_pass(2); push_pass(1); push_done(4);
    start_op(5);
    drain("len5", 200);

    // len=0 and len=1: no pass, ap_done caught by the second edge after start
    for (int l = 0; l < 2; l++) begin
      push_done(0);
      bus.len      = IDX_W'(l);
      bus.ap_start = 1'b1;
      @(negedge clk);
      check("short_done_early", int'(bus.ap_done), 0);
      @(negedge clk);
      bus.ap_start = 1'b0;
      check("short_done_latency", int'(bus.ap_done), 1);
      drain("short", 20);
    end

    // len=8 with swaps 1,1,0
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    passes = 3;
`else
    passes = 7;
`endif
    ready_dly = 0; done_dly = 2;
    swap_q.push_back(1'b1); swap_q.push_back(1'b1); swap_q.push_back(1'b0);
    for (int i = 0; i < passes; i++) push_pass(7 - i);
    push_done(passes);
    start_op(8);
    drain("len8", 400);

    // delayed acceptance: pass_start held four cycles, bound stable
    ready_dly = 3; done_dly = 2;
    push_pass(2); push_pass(1); push_done(2);
    start_op(3);
    drain("ready_delay", 200);

    // reset during WAIT of pass 2
    ready_dly = 0; done_dly = 8;
    push_pass(4); push_pass(3);
    start_op(5);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("reach_pass2", exp_q.size(), 0);
    #2 rst = 1'b1;
    #1;
    check("arst_ap_idle",    int'(bus.ap_idle),    1);
    check("arst_pass_start", int'(bus.pass_start), 0);
    check("arst_ap_done",    int'(bus.ap_done),    0);
    check("arst_pass_count", int'(bus.pass_count), 0);
    repeat (2) tick();
    rst = 1'b0;
    n = 0;
    while (resp_busy && n < 50) begin
      tick();
      n++;
    end
    check("resp_idle_after_reset", int'(resp_busy), 0);
    repeat (2) tick();
    done_dly = 3;
    push_pass(2); push_pass(1); push_done(2);
    start_op(3);
    drain("after_reset", 200);

    // ap_start held: back-to-back ops, stray starts ignored
    ready_dly = 0; done_dly = 1;
    push_pass(2); push_pass(1); push_done(2);
    push_pass(2); push_pass(1); push_done(2);
    bus.len      = IDX_W'(3);
    bus.ap_start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ap_done && n < 100);
    check("b2b_first_done", int'(bus.ap_done), 1);
    @(negedge clk);
    check("b2b_idle_gap", int'(bus.ap_idle), 1);
    @(negedge clk);
    check("b2b_second_accept", int'(bus.pass_start), 1);
    bus.len = IDX_W'(7);
    @(negedge clk);
    bus.ap_start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.pass_start && n < 50);
    bus.ap_start = 1'b1;
    @(negedge clk);
    bus.ap_start = 1'b0;
    drain("b2b", 200);
    check("b2b_final_idle", int'(bus.ap_idle), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
